s2p_frame: RTL and testbench
============================

S2P_FRAME -- requirements
Module: s2p_frame

Interface
REQ-001 Parameter W, default 8, data word width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  frame start; SHALL mark the sin bit sampled on the same edge as bit 0.
REQ-005 sin  input  1  serial data.
REQ-006 msb_first  input  1  bit order, sampled with start: 1 places the first bit in pout[W-1], 0 places it in pout[0].
REQ-007 pout  output  W  assembled word.
REQ-008 pout_valid  output  1  pout holds an unconsumed word.
REQ-009 pout_ready  input  1  consumer accepts; a transfer SHALL occur on an edge where pout_valid and pout_ready are both 1.
REQ-010 busy  output  1  frame in progress.
REQ-011 overrun  output  1  sticky flag; a completed word was dropped.
REQ-012 par_err  output  1  parity error for the word in pout; SHALL be valid while pout_valid = 1.

Function
REQ-013 FSM states: S_IDLE, S_SHIFT, S_PAR; S_PAR SHALL exist only with S2P_PARITY_EN.
REQ-014 start=1 in any state SHALL sample sin as bit 0, latch msb_first, clear the bit counter and enter S_SHIFT.
REQ-015 start=1 in S_SHIFT or S_PAR SHALL abort the current frame; no partial word SHALL be delivered.
REQ-016 In S_SHIFT with start=0, one bit SHALL be sampled per edge; the edge sampling bit W-1 SHALL complete the data word.
REQ-017 Without parity, the completion edge SHALL return to S_IDLE and present the word: pout_valid = 1 in the cycle after bit W-1 (latency 1 cycle).
REQ-018 busy SHALL be 1 exactly when state != S_IDLE.
REQ-019 Word presentation: if pout_valid = 0, or a transfer occurs on the same edge, pout SHALL load the new word and pout_valid SHALL be 1.
REQ-020 Word presentation: otherwise the new word SHALL be dropped, pout SHALL be unchanged and overrun SHALL be set.
REQ-021 pout_valid SHALL clear on a transfer edge with no new word; pout SHALL stay stable while pout_valid = 1 and pout_ready = 0.
REQ-022 Back-to-back frames: start is legal on the edge after completion; start on the bit W-1 edge SHALL abort per REQ-015.
REQ-023 overrun SHALL be cleared only by reset.

Reset
REQ-024 rst_n = 0 at an edge SHALL set state S_IDLE, counter 0, and pout, pout_valid, busy, overrun, par_err all to 0, regardless of frame progress.
REQ-025 While rst_n = 0, start SHALL be ignored; the first frame SHALL begin on a start edge with rst_n = 1.

Configuration
REQ-026 Macro S2P_PARITY_EN defined: after bit W-1 the FSM SHALL enter S_PAR and sample one even-parity bit on the next edge.
REQ-027 With S2P_PARITY_EN, the parity-sampling edge SHALL present the word; par_err SHALL be 1 if the XOR of the data and parity bits is 1; the word SHALL be delivered regardless.
REQ-028 Macro S2P_PARITY_EN undefined: no S_PAR cycle; the par_err port SHALL remain and be tied to 0.

Structure
REQ-029 Package s2p_pkg SHALL hold the state typedef s2p_state_t and the bit-order constants S2P_LSB_FIRST = 0 and S2P_MSB_FIRST = 1.
REQ-030 The one-entry valid/ready holding register SHALL be sub-module s2p_out_reg, parametrised by W+1 (word plus par_err).

Verification (W=8)
REQ-031 Reset 2 cycles; start with msb_first=1, sin bits 1,0,1,1,0,0,1,0; pout_ready=1 -> pout=8'hB2, pout_valid=1 for one cycle, on the cycle after the 8th bit.
REQ-032 Same bits with msb_first=0 -> pout=8'h4D.
REQ-033 pout_ready=0; frames 8'hB2 then 8'h0F back-to-back -> pout stays 8'hB2, overrun=1 after the 2nd frame completes; pout_ready=1 then drains 8'hB2 only.
REQ-034 Previous word pending; pout_ready=1 on the 2nd frame completion edge -> pout=2nd word, pout_valid stays 1, overrun=0.
REQ-035 start reasserted at bit 4, then 8 bits 8'hA5 MSB-first -> single word 8'hA5, no partial word; separately, rst_n=0 at bit 3 -> busy=0, pout_valid=0 next cycle.
REQ-036 S2P_PARITY_EN: 8'hB2 with parity bit 0 -> par_err=0; parity bit 1 -> par_err=1; both words delivered.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and constants for the s2p_frame serial-to-parallel block.
// S_PAR is only present when S2P_PARITY_EN is defined.
package s2p_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef S2P_PARITY_EN
      , S_PAR = 2'd2
`endif
   } s2p_state_t;

   localparam logic S2P_LSB_FIRST = 1'b0;
   localparam logic S2P_MSB_FIRST = 1'b1;

endpackage

// File: rtl/s2p_out_reg.sv
// One-entry valid/ready holding register; a new word arriving while the
// entry is full and not being consumed is dropped and flagged.
module s2p_out_reg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_drop,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic xfer;

   assign xfer    = out_valid & out_ready;
   assign in_drop = in_valid & out_valid & ~out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (in_valid && (!out_valid || xfer)) begin
         out_data  <= in_data;
         out_valid <= 1'b1;
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/s2p_frame.sv
// Serial-to-parallel framer with selectable bit order and sticky overrun.
// Define S2P_PARITY_EN to append and check one even-parity bit per word.
module s2p_frame
   import s2p_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sin,
   input  logic         msb_first,
   output logic [W-1:0] pout,
   output logic         pout_valid,
   input  logic         pout_ready,
   output logic         busy,
   output logic         overrun,
   output logic         par_err
);

   localparam int CW = $clog2(W);

   s2p_state_t   state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  shreg;
   logic [W-1:0]  shifted;
   logic          order;
   logic          last_bit;
   logic          word_valid;
   logic          word_par;
   logic [W-1:0]  word_data;
   logic          drop;
   logic [W:0]    out_data;

   // cnt holds the index of the last bit taken, so the bit W-1 edge sees W-2
   assign last_bit = (cnt == CW'(W - 2));

   // On a start edge the freshly presented bit order applies to bit 0
   always_comb begin
      if ((start ? msb_first : order) == S2P_MSB_FIRST)
         shifted = {shreg[W-2:0], sin};
      else
         shifted = {sin, shreg[W-1:1]};
   end

   always_comb begin
      word_valid = 1'b0;
      word_par   = 1'b0;
      word_data  = shifted;
      if (!start) begin
         case (state)
`ifdef S2P_PARITY_EN
            S_PAR: begin
               word_valid = 1'b1;
               word_data  = shreg;
               word_par   = (^shreg) ^ sin;
            end
`else
            S_SHIFT: word_valid = last_bit;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         order   <= S2P_LSB_FIRST;
         overrun <= 1'b0;
      end else begin
         if (drop)
            overrun <= 1'b1;
         if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            order <= msb_first;
            shreg <= shifted;
         end else begin
            case (state)
               S_SHIFT: begin
                  shreg <= shifted;
                  cnt   <= cnt + CW'(1);
                  if (last_bit) begin
`ifdef S2P_PARITY_EN
                     state <= S_PAR;
`else
                     state <= S_IDLE;
`endif
                  end
               end
`ifdef S2P_PARITY_EN
               S_PAR: state <= S_IDLE;
`endif
               default: ;
            endcase
         end
      end
   end

   assign busy = (state != S_IDLE);

   s2p_out_reg #(
      .W(W + 1)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   ({word_par, word_data}),
      .in_valid  (word_valid),
      .in_drop   (drop),
      .out_data  (out_data),
      .out_valid (pout_valid),
      .out_ready (pout_ready)
   );

   assign pout    = out_data[W-1:0];
   assign par_err = out_data[W];

endmodule

// File: tb/tb_s2p_frame.sv
// Self-checking bench for s2p_frame (W=8); scoreboard of delivered words.
module tb_s2p_frame;

   localparam int W = 8;
`ifdef S2P_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sin;
   logic         msb_first;
   logic [W-1:0] pout;
   logic         pout_valid;
   logic         pout_ready;
   logic         busy;
   logic         overrun;
   logic         par_err;

   int tests = 0;
   int fails = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   s2p_frame #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .sin        (sin),
      .msb_first  (msb_first),
      .pout       (pout),
      .pout_valid (pout_valid),
      .pout_ready (pout_ready),
      .busy       (busy),
      .overrun    (overrun),
      .par_err    (par_err)
   );

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // seq[7] is the first bit on the wire
   task automatic expect_word(input logic [7:0] seq, input logic msbf, input logic pflip);
      logic [7:0] w;
      w = msbf ? seq : rev8(seq);
      exp_q.push_back({PAR_EN ? pflip : 1'b0, w});
   endtask

   task automatic send_bits(input logic [7:0] seq, input logic msbf, input int n,
                            input logic rdy_last, input logic pflip);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start     = (i == 0);
         msb_first = msbf;
         sin       = seq[7-i];
         if (i == n - 1 && !(PAR_EN && n == 8)) pout_ready = rdy_last;
      end
      if (PAR_EN && n == 8) begin
         @(negedge clk);
         start      = 1'b0;
         sin        = (^seq) ^ pflip;
         pout_ready = rdy_last;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Transfers are judged just before the edge on which they happen
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (pout_valid === 1'b1 && pout_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_word got pout=%h par_err=%b, required no word", pout, par_err);
            end else begin
               e = exp_q.pop_front();
               if ({par_err, pout} !== e) begin
                  fails++;
                  $display("FAIL scoreboard got {par_err,pout}=%h, required %h", {par_err, pout}, e);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; sin = 1'b1; msb_first = 1'b1; pout_ready = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b, required 0", busy); end
      tests++; if (pout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b, required 0", pout_valid); end
      tests++; if (pout !== 8'h00) begin fails++; $display("FAIL reset_pout got %h, required 00", pout); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b, required 0", overrun); end
      tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL reset_par_err got %b, required 0", par_err); end
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_msb_first();
      pout_ready = 1'b1;
      expect_word(8'hB2, 1'b1, 1'b0);
      send_bits(8'hB2, 1'b1, 8, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (pout_valid !== 1'b1) begin fails++; $display("FAIL msb_valid got %b, required 1", pout_valid); end
      tests++; if (pout !== 8'hB2) begin fails++; $display("FAIL msb_pout got %h, required b2", pout); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL msb_busy_done got %b, required 0", busy); end
      @(negedge clk);
      tests++; if (pout_valid !== 1'b0) begin fails++; $display("FAIL msb_valid_one_cycle got %b, required 0", pout_valid); end
   endtask

   task automatic test_lsb_first();
      pout_ready = 1'b1;
      expect_word(8'hB2, 1'b0, 1'b0);
      send_bits(8'hB2, 1'b0, 8, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (pout_valid !== 1'b1) begin fails++; $display("FAIL lsb_valid got %b, required 1", pout_valid); end
      tests++; if (pout !== 8'h4D) begin fails++; $display("FAIL lsb_pout got %h, required 4d", pout); end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      pout_ready = 1'b0;
      expect_word(8'hB2, 1'b1, 1'b0);
      send_bits(8'hB2, 1'b1, 8, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_early got %b, required 0", overrun); end
      send_bits(8'h0F, 1'b1, 8, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (pout !== 8'hB2) begin fails++; $display("FAIL ovr_pout_hold got %h, required b2", pout); end
      tests++; if (pout_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b, required 1", pout_valid); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b, required 1", overrun); end
      pout_ready = 1'b1;
      @(negedge clk);
      tests++; if (pout_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain got %b, required 0", pout_valid); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b, required 1", overrun); end
      do_reset();
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_reset_clear got %b, required 0", overrun); end
   endtask

   task automatic test_back_to_back();
      pout_ready = 1'b0;
      expect_word(8'hB2, 1'b1, 1'b0);
      expect_word(8'h0F, 1'b1, 1'b0);
      send_bits(8'hB2, 1'b1, 8, 1'b0, 1'b0);
      @(negedge clk);
      send_bits(8'h0F, 1'b1, 8, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (pout !== 8'h0F) begin fails++; $display("FAIL b2b_pout got %h, required 0f", pout); end
      tests++; if (pout_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b, required 1", pout_valid); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b, required 0", overrun); end
      @(negedge clk);
      tests++; if (pout_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b, required 0", pout_valid); end
   endtask

   task automatic test_abort();
      pout_ready = 1'b1;
      expect_word(8'hA5, 1'b1, 1'b0);
      send_bits(8'hFF, 1'b1, 4, 1'b1, 1'b0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy got %b, required 1", busy); end
      send_bits(8'hA5, 1'b1, 8, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (pout !== 8'hA5) begin fails++; $display("FAIL abort_pout got %h, required a5", pout); end
      tests++; if (pout_valid !== 1'b1) begin fails++; $display("FAIL abort_valid got %b, required 1", pout_valid); end
      @(negedge clk);
      send_bits(8'hFF, 1'b1, 3, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b, required 0", busy); end
      tests++; if (pout_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b, required 0", pout_valid); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      tests++; if (pout_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_word got %b, required 0", pout_valid); end
   endtask

   task automatic test_parity();
`ifdef S2P_PARITY_EN
      pout_ready = 1'b1;
      expect_word(8'hB2, 1'b1, 1'b0);
      send_bits(8'hB2, 1'b1, 8, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL par_good got %b, required 0", par_err); end
      expect_word(8'hB2, 1'b1, 1'b1);
      send_bits(8'hB2, 1'b1, 8, 1'b1, 1'b1);
      @(negedge clk);
      tests++; if (par_err !== 1'b1) begin fails++; $display("FAIL par_bad got %b, required 1", par_err); end
      tests++; if (pout !== 8'hB2) begin fails++; $display("FAIL par_bad_pout got %h, required b2", pout); end
      @(negedge clk);
`else
      pout_ready = 1'b1;
      expect_word(8'h5A, 1'b1, 1'b0);
      send_bits(8'h5A, 1'b1, 8, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL par_tied got %b, required 0", par_err); end
      @(negedge clk);
`endif
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overrun();
      test_back_to_back();
      test_abort();
      test_parity();
      repeat (4) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_empty got %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
